// File: rtl/secuenciador_suma_multiciclo_if.sv
// Handshake and operand/result bus of the multi-cycle add/subtract sequencer.
interface secuenciador_suma_multiciclo_if #(
  parameter int W = 32
);
  logic         start_i;
  logic         resta_i;
  logic [W-1:0] operando1_i;
  logic [W-1:0] operando2_i;
  logic         cancel_i;
  logic         ack_i;
  logic         ready_o;
  logic         busy_o;
  logic         valid_o;
  logic [W-1:0] resultado_o;
  logic         carry_o;
  logic         overflow_o;

  modport master (
    output start_i, resta_i, operando1_i, operando2_i, cancel_i, ack_i,
    input  ready_o, busy_o, valid_o, resultado_o, carry_o, overflow_o
  );

  modport slave (
    input  start_i, resta_i, operando1_i, operando2_i, cancel_i, ack_i,
    output ready_o, busy_o, valid_o, resultado_o, carry_o, overflow_o
  );
endinterface

// File: rtl/secuenciador_suma_multiciclo.sv
// Multi-cycle add/subtract: one N-bit carry-lookahead slice per clock, LSB slice first,
// with the inter-slice carry held in a register.
module CarryLookAheadSumadorR #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_carry_in,
  output logic [N-1:0] o_result,
  output logic         o_carry_out
);
  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;
  logic         w_acc;
  logic         w_prod;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is expanded in terms of generate/propagate terms and the slice carry-in.
  always_comb begin
    w_c    = '0;
    w_acc  = 1'b0;
    w_prod = 1'b0;
    w_c[0] = i_carry_in;
    for (int i = 0; i < N; i++) begin
      w_acc  = w_g[i];
      w_prod = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc  = w_acc | (w_prod & w_g[j]);
        w_prod = w_prod & w_p[j];
      end
      w_c[i+1] = w_acc | (w_prod & i_carry_in);
    end
  end

  assign o_result    = w_p ^ w_c[N-1:0];
  assign o_carry_out = w_c[N];
endmodule

module secuenciador_suma_multiciclo #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  secuenciador_suma_multiciclo_if.slave    bus
);
  localparam int K  = W / N;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (((W % N) != 0) || (W < N)) begin : g_bad_params
    $error("secuenciador_suma_multiciclo: W must be a multiple of N and W >= N");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_res;
  logic           r_carry_o;
  logic           r_ovf;

  logic [N-1:0]   w_a_slice;
  logic [N-1:0]   w_b_slice;
  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic           w_last;
  logic           w_accept;

  assign w_last   = (r_cnt == CW'(K - 1));
  assign w_accept = (r_state == IDLE) && bus.start_i && !bus.cancel_i;

  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int k = 0; k < K; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_slice = r_a[k*N +: N];
        w_b_slice = r_b[k*N +: N];
      end
    end
  end

  CarryLookAheadSumadorR #(.N(N)) u_slice (
    .i_a         (w_a_slice),
    .i_b         (w_b_slice),
    .i_carry_in  (r_carry),
    .o_result    (w_sum),
    .o_carry_out (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // cancel_i wins over start_i in IDLE and acts like ack_i in DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = RUN;
      RUN: begin
        if (bus.cancel_i)  w_next = IDLE;
        else if (w_last)   w_next = DONE;
      end
      DONE: if (bus.ack_i || bus.cancel_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_carry_o <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.operando1_i;
      r_b     <= bus.resta_i ? ~bus.operando2_i : bus.operando2_i;
      r_carry <= bus.resta_i;
      r_cnt   <= '0;
    end else if ((r_state == RUN) && !bus.cancel_i) begin
      for (int k = 0; k < K; k++) begin
        if (r_cnt == CW'(k)) r_res[k*N +: N] <= w_sum;
      end
      r_carry <= w_cout;
      if (w_last) begin
        r_carry_o <= w_cout;
        r_ovf     <= (r_a[W-1] == r_b[W-1]) && (w_sum[N-1] != r_a[W-1]);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.ready_o     = (r_state == IDLE);
  assign bus.busy_o      = (r_state == RUN);
  assign bus.valid_o     = (r_state == DONE);
  assign bus.resultado_o = r_res;
  assign bus.carry_o     = r_carry_o;
  assign bus.overflow_o  = r_ovf;
endmodule

// File: doc/secuenciador_suma_multiciclo.md
Name: secuenciador_suma_multiciclo

Overview:
Multi-cycle add/subtract controller that runs a W-bit operation through a single N-bit CarryLookAheadSumadorR slice, one slice per clock, least significant slice first. The carry is held in a register between slices. It trades latency for area in the ALU path of the RISC-V core. Operands are accepted on a start/ready handshake, and the result is held on valid_o until the consumer acknowledges it.

Parameters:
N, 4, slice width in bits; width of the internal CarryLookAheadSumadorR instance.
W, 32, operand/result width. W must be a multiple of N and W >= N; elaboration fails otherwise.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start_i  input  1  request a new operation; accepted only when ready_o=1
resta_i  input  1  1 = subtract (operando1_i - operando2_i), 0 = add; sampled with start_i
operando1_i  input  W  first operand; sampled on the accepting edge
operando2_i  input  W  second operand; sampled on the accepting edge
cancel_i  input  1  abort the current operation
ack_i  input  1  consumer has taken the result
ready_o  output  1  block is in IDLE and can accept start_i
busy_o  output  1  block is in RUN
valid_o  output  1  block is in DONE; result outputs are stable
resultado_o  output  W  sum or difference
carry_o  output  1  final carry out; for subtract, 1 = no borrow
overflow_o  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; slice counter, carry register and operand registers clear.
  - resultado_o=0, carry_o=0, overflow_o=0, valid_o=0, busy_o=0, ready_o=1.
  - Reset asserted in any state, including mid-RUN, discards the operation with no valid_o.
- States: IDLE, RUN, DONE. ready_o/busy_o/valid_o decode the state directly; exactly one is high at any time.
- IDLE:
  - On an edge with start_i=1, latch operando1_i into A.
  - Latch B as operando2_i, or ~operando2_i when resta_i=1.
  - Carry register = resta_i; counter = 0; go to RUN.
- RUN, K = W/N cycles:
  - Slice i = counter feeds A[i*N+:N], B[i*N+:N] and the carry register into the adder.
  - On each edge, write the adder result into resultado_o[i*N+:N] and its CarryOut into the carry register; counter += 1.
  - On the edge processing slice K-1: carry_o = CarryOut; overflow_o = (A[W-1]==B[W-1]) && (result[W-1]!=A[W-1]), using B after any inversion; go to DONE.
- Latency: valid_o rises exactly K cycles after the accepting edge. For K=1 there is one RUN cycle.
- DONE:
  - Outputs stay stable and valid_o stays 1 until an edge with ack_i=1, then go to IDLE.
  - resultado_o, carry_o and overflow_o keep their values in IDLE until the next operation overwrites them slice by slice.
- start_i while in RUN or DONE is ignored; no queuing.
- cancel_i:
  - In RUN: go to IDLE on the next edge; valid_o is never asserted; resultado_o contents are undefined-but-stable and must not be consumed.
  - In DONE: same effect as ack_i.
  - In IDLE: cancel_i has priority over start_i; a simultaneous start_i is not accepted.
- ack_i outside DONE is ignored.
- The counter is $clog2(K) bits wide, with a minimum of 1 bit, and is compared against K-1. It never wraps in normal operation.

Test Plan:
1. W=8, N=4, add 0xFF+0x01, accepted at edge t -> RUN for 2 cycles, valid_o=1 from edge t+2, resultado_o=0x00, carry_o=1, overflow_o=0.
2. W=8, sub 0x80-0x01 -> resultado_o=0x7F, carry_o=1, overflow_o=1; then sub 0x00-0x01 -> 0xFF, carry_o=0, overflow_o=0.
3. W=8, add 0x7F+0x01 -> 0x80, carry_o=0, overflow_o=1. Hold ack_i=0 for 5 cycles -> valid_o and all outputs stable; ack_i=1 -> ready_o=1 next cycle.
4. start_i pulsed with new operands during RUN -> ignored, first result unchanged. cancel_i during RUN -> IDLE next edge, valid_o never rises. cancel_i+start_i together in IDLE -> not accepted.
5. rst_n pulled low asynchronously mid-RUN (between edges) -> outputs take reset values immediately. After release, a new add of 0x12+0x34 yields 0x46.
6. W=32, N=4, 0xFFFFFFFF+0x00000001 -> valid_o after 8 cycles, resultado_o=0, carry_o=1. W=4, N=4 (K=1), 0xF+0x8 with resta_i=0 -> 0x7, carry_o=1, overflow_o=1, latency 1.
